// File: rtl/sram_host_sequencer.sv
// Host-side command sequencer for the 16x16 SRAM/IMC controller: buffers
// read/write/IMC commands, drives the controller pins one command at a time, returns responses.
module sram_host_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_op,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        rw,
  output logic        imc_en,
  output logic        mem_en,
  output logic        en_dec,
  output logic [3:0]  address_input,
  output logic [15:0] IB_out,
  output logic [15:0] din,
  input  logic        halt,
  input  logic        busy_signal_output,
  input  logic        data_ready_signal_output,
  input  logic        writing_finished_signal_output,
  input  logic        SAEN,
  input  logic [15:0] sa_data
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP, DRAIN} state_t;

  state_t            state, state_d;
  logic [21:0]       fifo_mem [DEPTH];
  logic [21:0]       head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]   count, count_d;
  logic              push, pop, done;
  logic [1:0]        wop, wop_d;
  logic [3:0]        waddr, waddr_d;
  logic [15:0]       wdata, wdata_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              rw_d, imc_en_d, mem_en_d, en_dec_d;
  logic [3:0]        addr_d;
  logic [15:0]       ib_d, din_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [1:0]        rsp_op_d;
  logic [15:0]       rsp_data_d;

  assign push = cmd_valid && cmd_ready;
  assign head = fifo_mem[rd_ptr];
  assign done = ((wop == 2'b00) && data_ready_signal_output) ||
                ((wop == 2'b01) && writing_finished_signal_output) ||
                ((wop == 2'b10) && SAEN && imc_en);

  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + CNTW'(1);
    else if (!push && pop) count_d = count - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
  end

  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    wop_d       = wop;
    waddr_d     = waddr;
    wdata_d     = wdata;
    cnt_d       = cnt;
    rw_d        = rw;
    imc_en_d    = imc_en;
    mem_en_d    = mem_en;
    en_dec_d    = en_dec;
    addr_d      = address_input;
    ib_d        = IB_out;
    din_d       = din;
    rsp_valid_d = rsp_valid;
    rsp_op_d    = rsp_op;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if ((count != '0) && !halt) begin
          pop = 1'b1;
          {wop_d, waddr_d, wdata_d} = head;
          // Illegal op never touches the controller pins
          if (head[21:20] == 2'b11) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_op_d    = 2'b11;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        addr_d  = waddr;
        din_d   = wdata;
        ib_d    = wdata;
        cnt_d   = '0;
        state_d = WAIT;
        case (wop)
          2'b00:   begin rw_d = 1'b1; mem_en_d = 1'b1; en_dec_d = 1'b1; end
          2'b01:   begin rw_d = 1'b0; mem_en_d = 1'b1; en_dec_d = 1'b1; end
          default: begin imc_en_d = 1'b1; end
        endcase
      end
      WAIT: begin
        if (done) begin
          state_d = CAPTURE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rw_d        = 1'b1;
          imc_en_d    = 1'b0;
          mem_en_d    = 1'b0;
          en_dec_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_op_d    = wop;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      CAPTURE: begin
        rw_d        = 1'b1;
        imc_en_d    = 1'b0;
        mem_en_d    = 1'b0;
        en_dec_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_op_d    = wop;
        rsp_data_d  = (wop == 2'b01) ? 16'h0000 : sa_data;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // After IMC, halt is ignored once four drain cycles have elapsed
        if (!busy_signal_output && (!halt || ((wop == 2'b10) && (cnt == CW'(3))))) state_d = IDLE;
        if (cnt != CW'(3)) cnt_d = cnt + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    waddr <= waddr_d;
    wdata <= wdata_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      cmd_ready     <= 1'b0;
      state         <= IDLE;
      wop           <= 2'b00;
      cnt           <= '0;
      rw            <= 1'b1;
      imc_en        <= 1'b0;
      mem_en        <= 1'b0;
      en_dec        <= 1'b0;
      address_input <= '0;
      IB_out        <= '0;
      din           <= '0;
      rsp_valid     <= 1'b0;
      rsp_op        <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count         <= count_d;
      cmd_ready     <= (count_d != CNTW'(DEPTH));
      state         <= state_d;
      wop           <= wop_d;
      cnt           <= cnt_d;
      rw            <= rw_d;
      imc_en        <= imc_en_d;
      mem_en        <= mem_en_d;
      en_dec        <= en_dec_d;
      address_input <= addr_d;
      IB_out        <= ib_d;
      din           <= din_d;
      rsp_valid     <= rsp_valid_d;
      rsp_op        <= rsp_op_d;
      rsp_data      <= rsp_data_d;
      rsp_err       <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_sram_host_sequencer.sv
// Bench for sram_host_sequencer: a fake SRAM/IMC controller plus an in-order
// response scoreboard, checked every cycle, with directed scenarios.
module tb_sram_host_sequencer;
  localparam int DEPTH = 4, TIMEOUT = 32, DLY = 3;

  logic clk = 1'b0;
  logic reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cmd_op, rsp_op;
  logic [3:0] cmd_addr, address_input;
  logic [15:0] cmd_data, rsp_data, IB_out, din, sa_data;
  logic rw, imc_en, mem_en, en_dec, halt, busy_signal_output;
  logic data_ready_signal_output, writing_finished_signal_output, SAEN;

  typedef struct {logic [1:0] op; logic [3:0] addr; logic [15:0] cdata; logic [15:0] rdata; logic err;} exp_t;
  typedef struct {logic [1:0] op; logic [15:0] data; logic err;} rsp_t;
  exp_t expq[$];
  rsp_t rlog[$];
  logic [15:0] ref_mem [16];
  logic [15:0] ctl_mem [16];
  logic [15:0] imc_val;
  logic stuck;
  int n_checks = 0, n_pass = 0, pin_cycles = 0;

  sram_host_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rw(rw), .imc_en(imc_en), .mem_en(mem_en), .en_dec(en_dec),
    .address_input(address_input), .IB_out(IB_out), .din(din), .halt(halt),
    .busy_signal_output(busy_signal_output), .data_ready_signal_output(data_ready_signal_output),
    .writing_finished_signal_output(writing_finished_signal_output), .SAEN(SAEN), .sa_data(sa_data));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_rsp(input int idx, input logic [1:0] op, input logic [15:0] data, input logic err);
    if (idx < rlog.size()) begin
      chk("log_op", 32'(rlog[idx].op), 32'(op));
      chk("log_data", 32'(rlog[idx].data), 32'(data));
      chk("log_err", 32'(rlog[idx].err), 32'(err));
    end else chk("log_len", rlog.size(), idx + 1);
  endtask

  // Expected response is fixed when the command is accepted
  task automatic push(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data);
    exp_t e;
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) chk("push_accept", 0, 1);
    else begin
      e.op = op; e.addr = addr; e.cdata = data;
      if (op == 2'b11 || stuck) begin e.err = 1'b1; e.rdata = 16'h0; end
      else begin
        e.err = 1'b0;
        case (op)
          2'b00: e.rdata = ref_mem[addr];
          2'b01: begin e.rdata = 16'h0; ref_mem[addr] = data; end
          default: e.rdata = imc_val;
        endcase
      end
      expq.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while (expq.size() != 0 && i < bound) begin @(posedge clk); i++; end
    if (expq.size() != 0) chk("drain_wait", expq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_rlog(input int n, input int bound);
    int i = 0;
    while (rlog.size() < n && i < bound) begin @(posedge clk); i++; end
    #1;
  endtask

  // Fake controller: completes after DLY active cycles unless stuck
  initial begin
    int mcnt = 0;
    bit mdone = 0;
    data_ready_signal_output = 0; writing_finished_signal_output = 0; SAEN = 0; sa_data = 0;
    for (int i = 0; i < 16; i++) begin ctl_mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    forever begin
      @(negedge clk);
      data_ready_signal_output = 0; writing_finished_signal_output = 0; SAEN = 0;
      if (!(mem_en || imc_en)) begin mcnt = 0; mdone = 0; end
      else if (!mdone && !stuck) begin
        mcnt++;
        if (mcnt == DLY) begin
          mdone = 1;
          if (imc_en) begin SAEN = 1; sa_data = imc_val; end
          else if (rw) begin data_ready_signal_output = 1; sa_data = ctl_mem[address_input]; end
          else begin writing_finished_signal_output = 1; ctl_mem[address_input] = din; end
        end
      end
    end
  end

  // Per-cycle compare: response order/content, hold stability, pin legality
  initial begin
    bit hold_prev = 0;
    logic [1:0] prev_op;
    logic [15:0] prev_data;
    logic prev_err;
    logic [3:0] m;
    forever begin
      @(negedge clk);
      if (!reset_n) hold_prev = 0;
      else begin
        if (hold_prev)
          chk("rsp_hold", {12'h0, rsp_valid, rsp_op, rsp_data, rsp_err}, {12'h0, 1'b1, prev_op, prev_data, prev_err});
        if (rsp_valid && expq.size() == 0) chk("rsp_unexpected", 1, 0);
        else if (rsp_valid && rsp_ready) begin
          chk("rsp_op", 32'(rsp_op), 32'(expq[0].op));
          chk("rsp_data", 32'(rsp_data), 32'(expq[0].rdata));
          chk("rsp_err", 32'(rsp_err), 32'(expq[0].err));
          rlog.push_back('{rsp_op, rsp_data, rsp_err});
          expq.delete(0);
        end
        hold_prev = rsp_valid && !rsp_ready;
        prev_op = rsp_op; prev_data = rsp_data; prev_err = rsp_err;
        if (mem_en || imc_en) begin
          pin_cycles++;
          if (expq.size() == 0) chk("pins_unexpected", 1, 0);
          else begin
            case (expq[0].op)
              2'b00: m = 4'b0111;
              2'b01: m = 4'b0110;
              2'b10: m = 4'b1001;
              default: m = 4'b0001;
            endcase
            chk("pin_mode", 32'({imc_en, mem_en, en_dec, rw}), 32'(m));
            if (expq[0].op[1] == 1'b0) chk("pin_addr", 32'(address_input), 32'(expq[0].addr));
            if (expq[0].op == 2'b01) chk("pin_din", 32'(din), 32'(expq[0].cdata));
            if (expq[0].op == 2'b10) chk("pin_ib", 32'(IB_out), 32'(expq[0].cdata));
          end
        end else chk("pin_idle", 32'({imc_en, mem_en, en_dec, rw}), 32'h1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int seen_v, seen_p;
    reset_n = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0;
    rsp_ready = 1; halt = 0; busy_signal_output = 0; stuck = 0; imc_val = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rw", 32'(rw), 1);
    reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 1);

    // Write/read round trip
    rlog.delete(); pin_cycles = 0;
    push(2'b01, 4'd5, 16'hA5C3);
    push(2'b00, 4'd5, 16'h0);
    wait_idle(200);
    chk_rsp(0, 2'b01, 16'h0000, 1'b0);
    chk_rsp(1, 2'b00, 16'hA5C3, 1'b0);
    chk("rt_pin_cycles", pin_cycles, 8);

    // IMC
    rlog.delete(); imc_val = 16'h1234;
    push(2'b10, 4'd0, 16'h00FF);
    wait_idle(200);
    chk_rsp(0, 2'b10, 16'h1234, 1'b0);

    // busy holds DRAIN after a write
    rlog.delete(); busy_signal_output = 1;
    push(2'b01, 4'd3, 16'h1111);
    push(2'b00, 4'd3, 16'h0);
    wait_rlog(1, 100);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_rsp_count", rlog.size(), 1);
    chk("busy_no_issue", 32'(mem_en), 0);
    busy_signal_output = 0;
    wait_idle(200);
    chk_rsp(1, 2'b00, 16'h1111, 1'b0);

    // FIFO full, backpressure, wrap
    rlog.delete(); rsp_ready = 0;
    push(2'b01, 4'd1, 16'h0101);
    push(2'b01, 4'd2, 16'h0202);
    push(2'b00, 4'd1, 16'h0);
    push(2'b00, 4'd2, 16'h0);
    push(2'b01, 4'd7, 16'h7777);
    repeat (12) @(posedge clk);
    #1;
    chk("full_cmd_ready", 32'(cmd_ready), 0);
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_rsp_op", 32'(rsp_op), 1);
    chk("bp_rsp_data", 32'(rsp_data), 0);
    chk("bp_no_issue", 32'(mem_en), 0);
    rsp_ready = 1;
    push(2'b00, 4'd7, 16'h0);
    wait_idle(300);
    chk("full_rsp_count", rlog.size(), 6);
    chk_rsp(2, 2'b00, 16'h0101, 1'b0);
    chk_rsp(5, 2'b00, 16'h7777, 1'b0);

    // halt blocks issue
    rlog.delete(); halt = 1;
    push(2'b00, 4'd2, 16'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("halt_no_issue", 32'(mem_en), 0);
    chk("halt_no_rsp", rlog.size(), 0);
    halt = 0;
    wait_idle(200);
    chk_rsp(0, 2'b00, 16'h0202, 1'b0);

    // Timeout
    rlog.delete(); stuck = 1; pin_cycles = 0;
    push(2'b00, 4'd5, 16'h0);
    wait_idle(200);
    stuck = 0;
    chk_rsp(0, 2'b00, 16'h0000, 1'b1);
    chk("timeout_pin_cycles", pin_cycles, TIMEOUT);

    // Illegal op
    rlog.delete(); pin_cycles = 0;
    push(2'b11, 4'd4, 16'hFFFF);
    wait_idle(200);
    chk_rsp(0, 2'b11, 16'h0000, 1'b1);
    chk("illegal_pin_cycles", pin_cycles, 0);

    // Async reset mid-WAIT, with a second command queued
    rlog.delete(); stuck = 1;
    push(2'b00, 4'd1, 16'h0);
    for (int i = 0; i < 20 && !mem_en; i++) @(negedge clk);
    push(2'b01, 4'd9, 16'h9999);
    #3 reset_n = 0;
    #1;
    chk("rst_rsp", {12'h0, rsp_valid, rsp_op, rsp_data, rsp_err}, 0);
    chk("rst_pins", 32'({imc_en, mem_en, en_dec, rw}), 32'h1);
    chk("rst_addr", 32'(address_input), 0);
    chk("rst_ib", 32'(IB_out), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    expq.delete(); stuck = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    seen_v = 0; seen_p = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen_v++;
      if (mem_en || imc_en) seen_p++;
    end
    chk("post_rst_no_rsp", seen_v, 0);
    chk("post_rst_no_issue", seen_p, 0);
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // Normal operation after reset
    rlog.delete();
    push(2'b00, 4'd9, 16'h0);
    push(2'b00, 4'd5, 16'h0);
    wait_idle(200);
    chk_rsp(0, 2'b00, 16'h0000, 1'b0);
    chk_rsp(1, 2'b00, 16'hA5C3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
